rocc_cmd_issuer: RTL and testbench
==================================

Name: rocc_cmd_issuer

Overview:
- Core-side initiator for the RoCC command/response interface; drives an accelerator's rocc_cmd_* inputs and consumes its rocc_resp_* outputs.
- A simple host port (test harness, debug module or a light core model) submits custom instructions with operands. The block registers and issues them, tracks destination registers awaiting a response in a per-rd scoreboard, and returns responses to the host through a one-entry output buffer.

Parameters:
- XLEN, 64, operand/response data width.
- OPCODE, 7'h0B, value driven on rocc_cmd_bits_inst_opcode (custom-0).
- MAX_OUTSTANDING, 4, max commands with xd=1 awaiting response (1..32).
- TIMEOUT_CYCLES, 1024, response watchdog limit (optional feature only).

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- host_req_valid  in  1  host command valid.
- host_req_ready  out  1  host command accepted when valid&ready.
- host_req_funct  in  7  instruction funct field.
- host_req_rd  in  5  destination register index.
- host_req_xd  in  1  command expects a response.
- host_req_rs1  in  XLEN  operand 1.
- host_req_rs2  in  XLEN  operand 2.
- host_resp_valid  out  1  buffered response valid.
- host_resp_ready  in  1  host accepts response.
- host_resp_rd  out  5  response rd.
- host_resp_data  out  XLEN  response data.
- rocc_cmd_valid  out  1  command valid to accelerator.
- rocc_cmd_ready  in  1  accelerator accepts command.
- rocc_cmd_bits_inst_funct  out  7  registered funct.
- rocc_cmd_bits_inst_rs1, rocc_cmd_bits_inst_rs2  out  5 each  driven 5'd0.
- rocc_cmd_bits_inst_xd  out  1  registered xd.
- rocc_cmd_bits_inst_xs1, rocc_cmd_bits_inst_xs2  out  1 each  driven 1.
- rocc_cmd_bits_inst_rd  out  5  registered rd.
- rocc_cmd_bits_inst_opcode  out  7  OPCODE.
- rocc_cmd_bits_rs1, rocc_cmd_bits_rs2  out  XLEN each  registered operands.
- rocc_resp_valid  in  1  accelerator response valid.
- rocc_resp_ready  out  1  block accepts response.
- rocc_resp_bits_rd  in  5  response rd.
- rocc_resp_bits_data  in  XLEN  response data.
- rocc_busy  in  1  accelerator busy.
- idle  out  1  nothing in flight.
- err_unexpected_resp  out  1  sticky; response for non-pending rd.
- err_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (async assert, sync deassert): rocc_cmd_valid=0, host_resp_valid=0, pending[31:0]=0, out_cnt=0, errors=0, all data registers 0; idle=1 once rocc_busy=0.
- Command register (1 entry): host_req_ready = (!rocc_cmd_valid | rocc_cmd_ready) & !hazard.
- hazard = host_req_xd & (pending[host_req_rd] | out_cnt==MAX_OUTSTANDING), evaluated on registered pending/out_cnt only. A response retiring rd X in the same cycle does not clear the hazard for a new command to rd X; it issues the next cycle.
- On host accept: load fields, rocc_cmd_valid=1 next cycle. Latency host→rocc_cmd_valid is 1 cycle.
- Back-to-back issue is allowed when rocc_cmd_ready=1. Fields are stable while valid&!ready.
- Scoreboard: set pending[rd] and out_cnt+1 at host accept when xd=1. xd=0 commands are never tracked. rd=0 with xd=1 is tracked like any other rd.
- Response: rocc_resp_ready = !host_resp_valid | host_resp_ready.
  - On rocc_resp fire with pending[rd]=1: clear bit, out_cnt-1, load buffer (host_resp_valid next cycle).
  - Fire with pending[rd]=0: drop, set err_unexpected_resp, no scoreboard change.
- Simultaneous set and clear of out_cnt in one cycle: net unchanged. Set and clear on the same rd cannot coincide because of the hazard rule.
- idle = !rocc_cmd_valid & out_cnt==0 & !host_resp_valid & !rocc_busy.
- Errors clear only on reset.

Optional Feature:
- ROCC_CMD_ISSUER_TIMEOUT_EN defined:
  - A counter increments each cycle with out_cnt!=0 and no response fire; it resets to 0 on response fire or when out_cnt==0.
  - When it reaches TIMEOUT_CYCLES, err_timeout is set (sticky) and the counter saturates.
- Undefined: no counter; err_timeout tied 0.

Test Plan:
- Issue funct=3, rd=5, xd=1, rs1=10, rs2=20; accelerator asserts ready, then responds rd=5 data=30 → rocc_cmd_valid one cycle after accept; host_resp rd=5 data=30; pending[5] clears; idle=1.
- Two xd=1 commands to rd=7 back-to-back → second held (host_req_ready=0) until the rd=7 response fires, issued the cycle after.
- MAX_OUTSTANDING=4, five xd=1 commands to rd 1..5, no responses → fifth stalls; response rd=2 → fifth accepted next cycle.
- Response rd=9 with nothing pending → not forwarded, err_unexpected_resp=1 and remains set.
- host_resp_ready=0, two responses rd=1 then rd=2 → first buffered, rocc_resp_ready=0; release → rd=1 then rd=2 delivered in order.
- Macro defined, TIMEOUT_CYCLES=16, one xd=1 command never answered → err_timeout=1 after 16 cycles; macro undefined → err_timeout stays 0.

Source files
------------

// File: rtl/rocc_cmd_issuer_if.sv
// rocc_cmd_issuer_if: RoCC command/response bus between issuer (master) and accelerator (slave)
interface rocc_cmd_issuer_if #(parameter int XLEN = 64);
  logic            rocc_cmd_valid;
  logic            rocc_cmd_ready;
  logic [6:0]      rocc_cmd_bits_inst_funct;
  logic [4:0]      rocc_cmd_bits_inst_rs1;
  logic [4:0]      rocc_cmd_bits_inst_rs2;
  logic            rocc_cmd_bits_inst_xd;
  logic            rocc_cmd_bits_inst_xs1;
  logic            rocc_cmd_bits_inst_xs2;
  logic [4:0]      rocc_cmd_bits_inst_rd;
  logic [6:0]      rocc_cmd_bits_inst_opcode;
  logic [XLEN-1:0] rocc_cmd_bits_rs1;
  logic [XLEN-1:0] rocc_cmd_bits_rs2;
  logic            rocc_resp_valid;
  logic            rocc_resp_ready;
  logic [4:0]      rocc_resp_bits_rd;
  logic [XLEN-1:0] rocc_resp_bits_data;
  logic            rocc_busy;
  modport master (
    output rocc_cmd_valid, rocc_cmd_bits_inst_funct, rocc_cmd_bits_inst_rs1, rocc_cmd_bits_inst_rs2,
           rocc_cmd_bits_inst_xd, rocc_cmd_bits_inst_xs1, rocc_cmd_bits_inst_xs2, rocc_cmd_bits_inst_rd,
           rocc_cmd_bits_inst_opcode, rocc_cmd_bits_rs1, rocc_cmd_bits_rs2, rocc_resp_ready,
    input  rocc_cmd_ready, rocc_resp_valid, rocc_resp_bits_rd, rocc_resp_bits_data, rocc_busy
  );
  modport slave (
    input  rocc_cmd_valid, rocc_cmd_bits_inst_funct, rocc_cmd_bits_inst_rs1, rocc_cmd_bits_inst_rs2,
           rocc_cmd_bits_inst_xd, rocc_cmd_bits_inst_xs1, rocc_cmd_bits_inst_xs2, rocc_cmd_bits_inst_rd,
           rocc_cmd_bits_inst_opcode, rocc_cmd_bits_rs1, rocc_cmd_bits_rs2, rocc_resp_ready,
    output rocc_cmd_ready, rocc_resp_valid, rocc_resp_bits_rd, rocc_resp_bits_data, rocc_busy
  );
endinterface

// File: rtl/rocc_cmd_issuer.sv
// rocc_cmd_issuer: host-to-RoCC command issuer with per-rd scoreboard and one-entry response buffer; ROCC_CMD_ISSUER_TIMEOUT_EN adds a response watchdog
module rocc_cmd_issuer #(
  parameter int         XLEN            = 64,
  parameter logic [6:0] OPCODE          = 7'h0B,
  parameter int         MAX_OUTSTANDING = 4,
  parameter int         TIMEOUT_CYCLES  = 1024
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            host_req_valid,
  output logic            host_req_ready,
  input  logic [6:0]      host_req_funct,
  input  logic [4:0]      host_req_rd,
  input  logic            host_req_xd,
  input  logic [XLEN-1:0] host_req_rs1,
  input  logic [XLEN-1:0] host_req_rs2,
  output logic            host_resp_valid,
  input  logic            host_resp_ready,
  output logic [4:0]      host_resp_rd,
  output logic [XLEN-1:0] host_resp_data,
  rocc_cmd_issuer_if.master rocc,
  output logic            idle,
  output logic            err_unexpected_resp,
  output logic            err_timeout
);
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("rocc_cmd_issuer: illegal parameter configuration");
  end
  logic            cmd_valid, cmd_xd;
  logic [6:0]      cmd_funct;
  logic [4:0]      cmd_rd;
  logic [XLEN-1:0] cmd_rs1, cmd_rs2;
  logic [31:0]     pending, pending_n;
  logic [5:0]      out_cnt, out_cnt_n;
  logic            hazard, req_fire, track, resp_fire, resp_hit;
  assign hazard    = host_req_xd & (pending[host_req_rd] | (out_cnt == 6'(MAX_OUTSTANDING)));
  assign host_req_ready = (!cmd_valid | rocc.rocc_cmd_ready) & !hazard;
  assign req_fire  = host_req_valid & host_req_ready;
  assign track     = req_fire & host_req_xd;
  assign rocc.rocc_resp_ready = !host_resp_valid | host_resp_ready;
  assign resp_fire = rocc.rocc_resp_valid & rocc.rocc_resp_ready;
  assign resp_hit  = resp_fire & pending[rocc.rocc_resp_bits_rd];
  assign rocc.rocc_cmd_valid            = cmd_valid;
  assign rocc.rocc_cmd_bits_inst_funct  = cmd_funct;
  assign rocc.rocc_cmd_bits_inst_rs1    = 5'd0;
  assign rocc.rocc_cmd_bits_inst_rs2    = 5'd0;
  assign rocc.rocc_cmd_bits_inst_xd     = cmd_xd;
  assign rocc.rocc_cmd_bits_inst_xs1    = 1'b1;
  assign rocc.rocc_cmd_bits_inst_xs2    = 1'b1;
  assign rocc.rocc_cmd_bits_inst_rd     = cmd_rd;
  assign rocc.rocc_cmd_bits_inst_opcode = OPCODE;
  assign rocc.rocc_cmd_bits_rs1         = cmd_rs1;
  assign rocc.rocc_cmd_bits_rs2         = cmd_rs2;
  assign idle = !cmd_valid & (out_cnt == 6'd0) & !host_resp_valid & !rocc.rocc_busy;
  // scoreboard update: set on tracked accept, clear on matching response; the hazard keeps both off the same rd
  always_comb begin
    pending_n = (pending | (track ? 32'd1 << host_req_rd : 32'd0))
              & ~(resp_hit ? 32'd1 << rocc.rocc_resp_bits_rd : 32'd0);
    out_cnt_n = out_cnt + 6'(track) - 6'(resp_hit);
  end
  // command register, scoreboard state, response buffer and sticky unexpected-response flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid           <= 1'b0;
      cmd_xd              <= 1'b0;
      cmd_funct           <= '0;
      cmd_rd              <= '0;
      cmd_rs1             <= '0;
      cmd_rs2             <= '0;
      pending             <= '0;
      out_cnt             <= '0;
      host_resp_valid     <= 1'b0;
      host_resp_rd        <= '0;
      host_resp_data      <= '0;
      err_unexpected_resp <= 1'b0;
    end else begin
      cmd_valid <= req_fire | (cmd_valid & !rocc.rocc_cmd_ready);
      if (req_fire) begin
        cmd_xd    <= host_req_xd;
        cmd_funct <= host_req_funct;
        cmd_rd    <= host_req_rd;
        cmd_rs1   <= host_req_rs1;
        cmd_rs2   <= host_req_rs2;
      end
      pending         <= pending_n;
      out_cnt         <= out_cnt_n;
      host_resp_valid <= resp_hit | (host_resp_valid & !host_resp_ready);
      if (resp_hit) begin
        host_resp_rd   <= rocc.rocc_resp_bits_rd;
        host_resp_data <= rocc.rocc_resp_bits_data;
      end
      err_unexpected_resp <= err_unexpected_resp | (resp_fire & !pending[rocc.rocc_resp_bits_rd]);
    end
  end
`ifdef ROCC_CMD_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          err_tmo;
  // watchdog: count cycles with work outstanding and no response, saturating at the limit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tcnt    <= '0;
      err_tmo <= 1'b0;
    end else begin
      tcnt    <= (resp_fire || out_cnt == 6'd0) ? '0 : (tcnt == TW'(TIMEOUT_CYCLES)) ? tcnt : tcnt + TW'(1);
      err_tmo <= err_tmo | (tcnt == TW'(TIMEOUT_CYCLES));
    end
  end
  assign err_timeout = err_tmo;
`else
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// tb_rocc_cmd_issuer: directed scoreboard bench for rocc_cmd_issuer
module tb_rocc_cmd_issuer;
  typedef struct {
    logic [6:0]  f;
    logic [4:0]  rd;
    logic        xd;
    logic [63:0] a;
    logic [63:0] b;
  } cmd_t;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_req_valid = 1'b0, host_req_ready;
  logic [6:0]  host_req_funct = '0;
  logic [4:0]  host_req_rd = '0;
  logic        host_req_xd = 1'b0;
  logic [63:0] host_req_rs1 = '0, host_req_rs2 = '0;
  logic        host_resp_valid, host_resp_ready = 1'b1;
  logic [4:0]  host_resp_rd;
  logic [63:0] host_resp_data;
  logic        idle, err_unexpected_resp, err_timeout;
  int          total = 0, bad = 0, n;
  cmd_t        cq[$];
  logic [68:0] rq[$];
  rocc_cmd_issuer_if #(.XLEN(64)) rif ();
  rocc_cmd_issuer #(.XLEN(64), .OPCODE(7'h0B), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready), .host_req_funct(host_req_funct),
    .host_req_rd(host_req_rd), .host_req_xd(host_req_xd), .host_req_rs1(host_req_rs1), .host_req_rs2(host_req_rs2),
    .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready), .host_resp_rd(host_resp_rd),
    .host_resp_data(host_resp_data), .rocc(rif), .idle(idle),
    .err_unexpected_resp(err_unexpected_resp), .err_timeout(err_timeout)
  );
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  // command monitor: every command handed to the accelerator must match the oldest expected one
  always @(negedge clock) begin
    if (reset_n && rif.rocc_cmd_valid && rif.rocc_cmd_ready) begin
      if (cq.size() == 0) chk("cmd_unexpected", 64'd1, 64'd0);
      else begin
        cmd_t e;
        e = cq.pop_front();
        chk("cmd_funct", 64'(rif.rocc_cmd_bits_inst_funct), 64'(e.f));
        chk("cmd_rd", 64'(rif.rocc_cmd_bits_inst_rd), 64'(e.rd));
        chk("cmd_xd", 64'(rif.rocc_cmd_bits_inst_xd), 64'(e.xd));
        chk("cmd_rs1", rif.rocc_cmd_bits_rs1, e.a);
        chk("cmd_rs2", rif.rocc_cmd_bits_rs2, e.b);
        chk("cmd_opc", 64'(rif.rocc_cmd_bits_inst_opcode), 64'h0B);
        chk("cmd_fixed", 64'({rif.rocc_cmd_bits_inst_rs1, rif.rocc_cmd_bits_inst_rs2,
                              rif.rocc_cmd_bits_inst_xs1, rif.rocc_cmd_bits_inst_xs2}), 64'h3);
      end
    end
  end
  // response monitor: host-side responses must arrive in the expected order
  always @(negedge clock) begin
    if (reset_n && host_resp_valid && host_resp_ready) begin
      if (rq.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
      else begin
        logic [68:0] e;
        e = rq.pop_front();
        chk("resp_rd", 64'(host_resp_rd), 64'(e[68:64]));
        chk("resp_data", host_resp_data, e[63:0]);
      end
    end
  end
  task automatic tk(input int c);
    repeat (c) @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic [6:0] f, input logic [4:0] rd, input logic xd,
                       input logic [63:0] a, input logic [63:0] b, output int w);
    host_req_valid = 1'b1; host_req_funct = f; host_req_rd = rd; host_req_xd = xd;
    host_req_rs1 = a; host_req_rs2 = b;
    w = 0;
    @(negedge clock);
    while (!host_req_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (!host_req_ready) chk("issue_wait", 64'd0, 64'd1);
    else cq.push_back('{f, rd, xd, a, b});
    tk(1);
    host_req_valid = 1'b0;
  endtask
  task automatic resp(input logic [4:0] rd, input logic [63:0] d, input logic fwd);
    int w = 0;
    rif.rocc_resp_valid = 1'b1; rif.rocc_resp_bits_rd = rd; rif.rocc_resp_bits_data = d;
    @(negedge clock);
    while (!rif.rocc_resp_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (!rif.rocc_resp_ready) chk("resp_wait", 64'd0, 64'd1);
    else if (fwd) rq.push_back({rd, d});
    tk(1);
    rif.rocc_resp_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    rif.rocc_cmd_ready = 1'b0; rif.rocc_resp_valid = 1'b0; rif.rocc_resp_bits_rd = '0;
    rif.rocc_resp_bits_data = '0; rif.rocc_busy = 1'b0;
    tk(3);
    @(negedge clock);
    chk("rst_cmd_valid", 64'(rif.rocc_cmd_valid), 64'd0);
    chk("rst_resp_valid", 64'(host_resp_valid), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_errs", 64'({err_unexpected_resp, err_timeout}), 64'd0);
    tk(1);
    reset_n = 1'b1;
    tk(1);
    // single command, accelerator initially stalled, then answered
    issue(7'd3, 5'd5, 1'b1, 64'd10, 64'd20, n);
    chk("t1_wait", 64'(n), 64'd0);
    chk("t1_latency", 64'(rif.rocc_cmd_valid), 64'd1);
    chk("t1_not_idle", 64'(idle), 64'd0);
    tk(2);
    chk("t1_hold_valid", 64'(rif.rocc_cmd_valid), 64'd1);
    chk("t1_hold_rd", 64'(rif.rocc_cmd_bits_inst_rd), 64'd5);
    rif.rocc_cmd_ready = 1'b1;
    tk(1);
    chk("t1_cmd_gone", 64'(rif.rocc_cmd_valid), 64'd0);
    resp(5'd5, 64'd30, 1'b1);
    chk("t1_resp_valid", 64'(host_resp_valid), 64'd1);
    tk(1);
    chk("t1_idle", 64'(idle), 64'd1);
    // same-rd hazard: second rd=7 waits for the first response and issues the cycle after
    issue(7'd4, 5'd7, 1'b1, 64'h70, 64'h71, n);
    host_req_valid = 1'b1; host_req_rd = 5'd7; host_req_xd = 1'b1;
    @(negedge clock);
    chk("t2_stall", 64'(host_req_ready), 64'd0);
    tk(1);
    rif.rocc_resp_valid = 1'b1; rif.rocc_resp_bits_rd = 5'd7; rif.rocc_resp_bits_data = 64'h77;
    @(negedge clock);
    chk("t2_same_cycle_stall", 64'(host_req_ready), 64'd0);
    chk("t2_resp_ready", 64'(rif.rocc_resp_ready), 64'd1);
    rq.push_back({5'd7, 64'h77});
    tk(1);
    rif.rocc_resp_valid = 1'b0;
    issue(7'd5, 5'd7, 1'b1, 64'h72, 64'h73, n);
    chk("t2_next_cycle", 64'(n), 64'd0);
    resp(5'd7, 64'h78, 1'b1);
    // outstanding limit of four
    for (int i = 1; i <= 4; i++) begin
      issue(7'd6, 5'(i), 1'b1, 64'(i), 64'(i * 2), n);
      chk("t3_fill", 64'(n), 64'd0);
    end
    host_req_valid = 1'b1; host_req_rd = 5'd5; host_req_xd = 1'b1;
    @(negedge clock);
    chk("t3_full_stall", 64'(host_req_ready), 64'd0);
    tk(1);
    @(negedge clock);
    chk("t3_full_stall2", 64'(host_req_ready), 64'd0);
    tk(1);
    resp(5'd2, 64'h22, 1'b1);
    issue(7'd6, 5'd5, 1'b1, 64'd5, 64'd10, n);
    chk("t3_fifth_next", 64'(n), 64'd0);
    resp(5'd1, 64'h11, 1'b1);
    resp(5'd3, 64'h33, 1'b1);
    resp(5'd4, 64'h44, 1'b1);
    resp(5'd5, 64'h55, 1'b1);
    // untracked command never blocks on the scoreboard
    issue(7'd1, 5'd9, 1'b0, 64'd1, 64'd2, n);
    chk("t3_xd0", 64'(n), 64'd0);
    tk(1);
    chk("t3_idle", 64'(idle), 64'd1);
    // unexpected response is dropped and flagged sticky
    resp(5'd9, 64'h99, 1'b0);
    chk("t4_err", 64'(err_unexpected_resp), 64'd1);
    chk("t4_no_fwd", 64'(host_resp_valid), 64'd0);
    tk(4);
    chk("t4_sticky", 64'(err_unexpected_resp), 64'd1);
    // back-pressure from the host: second response waits behind the buffer
    issue(7'd2, 5'd1, 1'b1, 64'd0, 64'd0, n);
    issue(7'd2, 5'd2, 1'b1, 64'd0, 64'd0, n);
    host_resp_ready = 1'b0;
    resp(5'd1, 64'h101, 1'b1);
    rif.rocc_resp_valid = 1'b1; rif.rocc_resp_bits_rd = 5'd2; rif.rocc_resp_bits_data = 64'h202;
    @(negedge clock);
    chk("t5_blocked", 64'(rif.rocc_resp_ready), 64'd0);
    chk("t5_buf_rd", 64'(host_resp_rd), 64'd1);
    tk(1);
    @(negedge clock);
    chk("t5_blocked2", 64'(rif.rocc_resp_ready), 64'd0);
    tk(1);
    host_resp_ready = 1'b1;
    rq.push_back({5'd2, 64'h202});
    tk(1);
    rif.rocc_resp_valid = 1'b0;
    tk(2);
    chk("t5_idle", 64'(idle), 64'd1);
    // watchdog on an unanswered command
    issue(7'd3, 5'd10, 1'b1, 64'd1, 64'd1, n);
    tk(5);
    chk("t6_early", 64'(err_timeout), 64'd0);
    tk(20);
`ifdef ROCC_CMD_ISSUER_TIMEOUT_EN
    chk("t6_timeout", 64'(err_timeout), 64'd1);
`else
    chk("t6_timeout", 64'(err_timeout), 64'd0);
`endif
    rif.rocc_busy = 1'b1;
    resp(5'd10, 64'hA0, 1'b1);
    tk(2);
    chk("t6_busy_not_idle", 64'(idle), 64'd0);
    rif.rocc_busy = 1'b0;
    tk(1);
    chk("end_idle", 64'(idle), 64'd1);
    chk("end_cq", 64'(cq.size()), 64'd0);
    chk("end_rq", 64'(rq.size()), 64'd0);
    chk("end_err_sticky", 64'(err_unexpected_resp), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
